// File: rtl/soc_pio_ctrl_pkg.sv
// soc_pio_ctrl_pkg: shared op/state encodings and default PIO register offsets
package soc_pio_ctrl_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_READ = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP, RMW_RD, RMW_WAIT, RMW_WR} state_e;
  localparam int DATA_ADDR = 0;
  localparam int SET_ADDR = 4;
  localparam int CLR_ADDR = 5;
endpackage

// File: rtl/soc_pio_ctrl_master.sv
// soc_pio_ctrl_master: Avalon-MM initiator driving a PIO slave from a command/response port
// Define SOC_PIO_CTRL_MASTER_RMW_EN to do set/clear as read-modify-write on offset 0.
module soc_pio_ctrl_master
  import soc_pio_ctrl_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32,
  parameter int READ_LATENCY = 1,
  parameter int SET_ADDR = soc_pio_ctrl_pkg::SET_ADDR,
  parameter int CLR_ADDR = soc_pio_ctrl_pkg::CLR_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);
  state_e state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0] cnt;
  logic wr_st, strobe;
`ifdef SOC_PIO_CTRL_MASTER_RMW_EN
  op_e op_q;
`endif
  assign wr_st = state == WRITE || state == RMW_WR;
  assign strobe = wr_st || state == RD_ISSUE || state == RMW_RD;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign avm_chipselect = strobe;
  assign avm_write_n = !wr_st;
  assign avm_address = strobe ? addr_q : '0;
  assign avm_writedata = wr_st ? data_q : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      cnt <= '0;
      rsp_data <= '0;
`ifdef SOC_PIO_CTRL_MASTER_RMW_EN
      op_q <= OP_WRITE;
`endif
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          data_q <= cmd_data;
`ifdef SOC_PIO_CTRL_MASTER_RMW_EN
          op_q <= op_e'(cmd_op);
          addr_q <= cmd_op[1] ? ADDR_W'(DATA_ADDR) : cmd_addr;
          state <= cmd_op == OP_READ ? RD_ISSUE : cmd_op == OP_WRITE ? WRITE : RMW_RD;
`else
          addr_q <= cmd_op == OP_SET ? ADDR_W'(SET_ADDR) : cmd_op == OP_CLR ? ADDR_W'(CLR_ADDR) : cmd_addr;
          state <= cmd_op == OP_READ ? RD_ISSUE : WRITE;
`endif
        end
        WRITE: if (!avm_waitrequest) begin
          rsp_data <= '0;
          state <= RESP;
        end
        RD_ISSUE: if (!avm_waitrequest) begin
          cnt <= 2'(READ_LATENCY - 1);
          state <= RD_WAIT;
        end
        RD_WAIT: if (cnt == 0) begin
          rsp_data <= avm_readdata;
          state <= RESP;
        end else cnt <= cnt - 2'd1;
`ifdef SOC_PIO_CTRL_MASTER_RMW_EN
        RMW_RD: if (!avm_waitrequest) begin
          cnt <= 2'(READ_LATENCY - 1);
          state <= RMW_WAIT;
        end
        RMW_WAIT: if (cnt == 0) begin
          data_q <= op_q == OP_SET ? avm_readdata | data_q : avm_readdata & ~data_q;
          state <= RMW_WR;
        end else cnt <= cnt - 2'd1;
        RMW_WR: if (!avm_waitrequest) begin
          rsp_data <= data_q;
          state <= RESP;
        end
`endif
        default: state <= IDLE;
      endcase
endmodule

// File: doc/soc_pio_ctrl_master.md
# soc_pio_ctrl_master

Avalon-MM initiator that drives a single PIO control-register slave from a simple command/response port. It serves the fabric-side data-register layout: offset 0 is the data/in-port register, offset 4 is bit-set and offset 5 is bit-clear. Local control logic uses it to write, read, set or clear bits without a CPU. It sits between sequencer logic and the PIO slave's s1 port.

## Interface
- ADDR_W, 3, Avalon address width.
- DATA_W, 32, data width.
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range 1..4.
- SET_ADDR, 4, bit-set register offset.
- CLR_ADDR, 5, bit-clear register offset.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  operation: 0 write, 1 read, 2 set bits, 3 clear bits.
- cmd_addr  in  ADDR_W  register offset for write/read; ignored for set/clear.
- cmd_data  in  DATA_W  write data or bit mask.
- rsp_valid  out  1  one-cycle completion pulse, one per command.
- rsp_data  out  DATA_W  read data; 0 for write/set/clear, except in the RMW build (see Configuration).
- avm_address  out  ADDR_W  Avalon address.
- avm_chipselect  out  1  Avalon chipselect.
- avm_write_n  out  1  Avalon write strobe, active-low.
- avm_writedata  out  DATA_W  Avalon write data.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_waitrequest  in  1  slave stall; tie to 0 for the zero-wait PIO.

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP. The RMW build adds RMW_RD, RMW_WAIT and RMW_WR.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch op, addr and data.
  - Write goes to WRITE. Read goes to RD_ISSUE.
  - Set/clear go to WRITE with address SET_ADDR or CLR_ADDR and writedata = mask.
- WRITE: chipselect=1, write_n=0, address and writedata held. Stay while waitrequest=1; otherwise go to RESP.
- RD_ISSUE: chipselect=1, write_n=1. Stay while waitrequest=1; otherwise load the latency counter with READ_LATENCY-1 and go to RD_WAIT.
- RD_WAIT: bus idle. The counter decrements to 0. On the cycle the counter reads 0, capture avm_readdata into rsp_data, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Bus idle values: chipselect=0, write_n=1, address=0, writedata=0.
- One command is outstanding at a time. cmd_ready is low in every state except IDLE.
- rsp_data holds its value until the next completion.
- Reset:
  - Any state goes to IDLE. All outputs return to idle values; rsp_valid=0, rsp_data=0, cmd_ready=1 after deassertion.
  - An in-flight transaction is abandoned with no response.

## Timing
- Accept on cycle 0.
- Write or set/clear: bus strobe in cycle 1 (plus waitrequest stalls); rsp_valid in cycle 2 with no stall.
- Read: strobe in cycle 1; data sampled at the end of cycle 1+READ_LATENCY; rsp_valid in cycle 2+READ_LATENCY.
- Next command can be accepted in the cycle after rsp_valid.
- cmd_valid asserted during a busy state is ignored until IDLE. The command must be held stable by the source.
- waitrequest asserted for N cycles extends the strobe by exactly N cycles.

## Configuration
- SOC_PIO_CTRL_MASTER_RMW_EN defined:
  - Set/clear are done as read-modify-write on offset 0: RMW_RD, then RMW_WAIT (READ_LATENCY), then RMW_WR writing rd|mask (set) or rd&~mask (clear), then RESP.
  - rsp_data = the value written.
  - Correct only when the slave's in-port reads back its out-port.
- Undefined: set/clear use the SET_ADDR and CLR_ADDR single writes described above.

## Structure
- Shared package soc_pio_ctrl_pkg:
  - Op encoding enum (OP_WRITE, OP_READ, OP_SET, OP_CLR).
  - State enum.
  - Default offset constants DATA_ADDR=0, SET_ADDR=4, CLR_ADDR=5.
- No sub-module. The latency counter and FSM are a single module.

## Test plan
- Write 0xDEADBEEF to offset 0, waitrequest=0: strobe in cycle 1 with address 0, write_n=0; rsp_valid in cycle 2; rsp_data=0.
- Read offset 0 with slave readdata 0x12345678, READ_LATENCY=1: rsp_valid in cycle 3, rsp_data=0x12345678. Repeat with READ_LATENCY=3: rsp_valid in cycle 5.
- Set mask 0x0000_00F0 in the default build: single write to address 4, data 0xF0. Clear mask 0x0F: write to address 5. In the RMW build with readback 0x0000_1100, set 0xF0 writes 0x0000_11F0 to offset 0, and rsp_data=0x11F0.
- waitrequest held high for 3 cycles during a write: strobe lasts 4 cycles and rsp_valid follows one cycle later; cmd_ready stays 0 throughout.
- Back-to-back cmd_valid: the second command is accepted only in the cycle after the first rsp_valid. No command is lost or duplicated.
- Reset asserted in RD_WAIT: outputs go idle immediately, with no rsp_valid; the first command after release completes normally.
